// File: rtl/rc5_pkg.sv
// Shared constants, state encoding and size helpers for the RC5-8 key schedule.
package rc5_pkg;

   localparam int W = 8;
   localparam logic [W-1:0] P8 = 8'hB7;
   localparam logic [W-1:0] Q8 = 8'h9F;

   typedef enum logic [1:0] {IDLE, LOAD, MIX, DONE} ks_state_e;

   function automatic int ks_tsize(input int rounds);
      return 2 * (rounds + 1);
   endfunction

   // Mixing iterations: three sweeps over the larger of the S and L tables.
   function automatic int ks_iters(input int rounds, input int key_bytes);
      int t;
      t = ks_tsize(rounds);
      return 3 * ((t > key_bytes) ? t : key_bytes);
   endfunction

endpackage

// File: rtl/rc5_rotl8.sv
// Combinational 8-bit left rotate by a 3-bit amount.
module rc5_rotl8
   import rc5_pkg::*;
(
   input  logic [W-1:0] data_i,
   input  logic [2:0]   amt_i,
   output logic [W-1:0] data_o
);

   // A zero amount shifts right by the full width, which contributes nothing.
   assign data_o = (data_i << amt_i) | (data_i >> (4'(W) - {1'b0, amt_i}));

endmodule

// File: rtl/rc5_key_sched_8bit.sv
// RC5-8 key expansion into the S round-key table, with a combinational read port.
// Optional macro RC5_KS_READ_GUARD_EN hides the table until expansion is done.
module rc5_key_sched_8bit
   import rc5_pkg::*;
#(
   parameter  int ROUNDS    = 12,
   parameter  int KEY_BYTES = 8,
   localparam int T         = ks_tsize(ROUNDS),
   localparam int AW        = $clog2(T)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   key_start_i,
   input  logic [8*KEY_BYTES-1:0] key_in_i,
   output logic                   busy_o,
   output logic                   key_done_o,
   input  logic [AW-1:0]          s_addr_i,
   output logic [W-1:0]           s_data_o
);

   localparam int N  = ks_iters(ROUNDS, KEY_BYTES);
   localparam int JW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam int NW = $clog2(N);
   localparam logic [AW-1:0] I_LAST = AW'(T - 1);
   localparam logic [JW-1:0] J_LAST = JW'(KEY_BYTES - 1);
   localparam logic [NW-1:0] N_LAST = NW'(N - 1);

   ks_state_e state_q, state_d;

   logic [W-1:0]  s_q [T];
   logic [W-1:0]  l_q [KEY_BYTES];
   logic [W-1:0]  a_q, b_q, acc_q;
   logic [AW-1:0] i_q;
   logic [JW-1:0] j_q;
   logic [NW-1:0] n_q;

   logic          start_ok;
   logic [W-1:0]  a_sum, a_new, b_sum, b_new, s_rd;
   logic [2:0]    b_amt;

   assign start_ok = key_start_i && (state_q == IDLE || state_q == DONE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (key_start_i)     state_d = LOAD;
         LOAD:    if (i_q == I_LAST)   state_d = MIX;
         MIX:     if (n_q == N_LAST)   state_d = DONE;
         DONE:    if (key_start_i)     state_d = LOAD;
         default:                      state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o     = (state_q == LOAD) || (state_q == MIX);
      key_done_o = (state_q == DONE);
   end

   // A' feeds the B rotate in the same cycle; (A'+B) mod 8 needs only the low bits.
   assign a_sum = s_q[i_q] + a_q + b_q;
   assign b_sum = l_q[j_q] + a_new + b_q;
   assign b_amt = a_new[2:0] + b_q[2:0];

   rc5_rotl8 u_rot_a (.data_i(a_sum), .amt_i(3'd3), .data_o(a_new));
   rc5_rotl8 u_rot_b (.data_i(b_sum), .amt_i(b_amt), .data_o(b_new));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < T; k++)         s_q[k] <= '0;
         for (int k = 0; k < KEY_BYTES; k++) l_q[k] <= '0;
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         i_q   <= '0;
         j_q   <= '0;
         n_q   <= '0;
      end else if (start_ok) begin
         for (int k = 0; k < KEY_BYTES; k++) l_q[k] <= key_in_i[8*k +: 8];
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= P8;
         i_q   <= '0;
         j_q   <= '0;
         n_q   <= '0;
      end else begin
         case (state_q)
            LOAD: begin
               s_q[i_q] <= acc_q;
               acc_q    <= acc_q + Q8;
               i_q      <= (i_q == I_LAST) ? '0 : i_q + 1'b1;
               j_q      <= '0;
               n_q      <= '0;
            end
            MIX: begin
               s_q[i_q] <= a_new;
               a_q      <= a_new;
               l_q[j_q] <= b_new;
               b_q      <= b_new;
               i_q      <= (i_q == I_LAST) ? '0 : i_q + 1'b1;
               j_q      <= (j_q == J_LAST) ? '0 : j_q + 1'b1;
               n_q      <= n_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign s_rd = ({1'b0, s_addr_i} < (AW+1)'(T)) ? s_q[s_addr_i] : '0;

`ifdef RC5_KS_READ_GUARD_EN
   assign s_data_o = key_done_o ? s_rd : '0;
`else
   assign s_data_o = s_rd;
`endif

endmodule
